spram_arbiter: RTL

- Two-requester arbiter and sequencer for one single-port synchronous RAM.
- The RAM registers its address, so read data appears one cycle after the address is presented.
- Shares the single RAM port between requester 0 (fetch side) and requester 1 (data side).
- Issues at most one access per cycle, returns read data with 1-cycle latency, and holds unaccepted read responses.

---
 rtl/spram_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/spram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous RAM with 1-cycle read latency.
// Optional macro SPRAM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to requester 0.
module spram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data0,
    output logic [DATA_WIDTH-1:0] rsp_data1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic [1:0]            pend_q, pend_d;
    logic [1:0]            byp_q, byp_d;
    logic [DATA_WIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic [1:0]            elig, grant, rd_grant;

`ifdef SPRAM_ARB_RR_EN
    logic ptr_q, ptr_d;
`endif

    // rsp_valid is gated by rst so a response in flight when reset hits is dropped immediately.
    always_comb begin
        rsp_valid = rst ? 2'b00 : pend_q;
        elig      = req_valid & (~pend_q | (rsp_valid & rsp_ready));
        grant     = 2'b00;
        if (!rst) begin
`ifdef SPRAM_ARB_RR_EN
            if (elig == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
            else               grant = elig;
`else
            grant[0] = elig[0];
            grant[1] = elig[1] & ~elig[0];
`endif
        end
        req_ready = grant;
        rd_grant  = grant & ~req_we;
    end

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = |(req_we & grant);
        if (grant[0]) begin
            ram_addr = req_addr0;
            ram_din  = req_wdata0;
        end else if (grant[1]) begin
            ram_addr = req_addr1;
            ram_din  = req_wdata1;
        end
    end

    // RAM output is only valid for the requester in its bypass cycle; afterwards the hold register answers.
    assign rsp_data0 = byp_q[0] ? ram_dout : hold0_q;
    assign rsp_data1 = byp_q[1] ? ram_dout : hold1_q;

    always_comb begin
        pend_d  = rd_grant | (pend_q & ~(rsp_valid & rsp_ready));
        byp_d   = rd_grant;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        if (byp_q[0] && !rsp_ready[0]) hold0_d = ram_dout;
        if (byp_q[1] && !rsp_ready[1]) hold1_d = ram_dout;
    end

`ifdef SPRAM_ARB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant[0])      ptr_d = 1'b1;
        else if (grant[1]) ptr_d = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 2'b00;
            byp_q   <= 2'b00;
            hold0_q <= '0;
            hold1_q <= '0;
`ifdef SPRAM_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            pend_q  <= pend_d;
            byp_q   <= byp_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
`ifdef SPRAM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule
